// File: rtl/ucisc_pkg.sv
// Shared widths and fetch FSM encoding for the uCISC front end.
package ucisc_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding assembled {instr, pc} entries between fetch and decode.
module fetch_queue
  import ucisc_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_W + WORD_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q == CNT_W'(DEPTH - 1));
  assign empty       = (count_q == '0);
  assign head_data   = mem_q[rd_ptr_q];
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;

  // Pointers wrap naturally because DEPTH is restricted to powers of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Two-word instruction fetch: reads hi/lo words from memory and queues assembled instructions.
module instruction_fetch
  import ucisc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 16'h0000,
  parameter int unsigned       QUEUE_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect,
  input  logic [WORD_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [WORD_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [WORD_W-1:0]  instr_pc
);

  localparam int unsigned ENTRY_W = INSTR_W + WORD_W;

  fetch_state_e        state_q, state_d;
  logic [WORD_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0]   hi_q, hi_d;
  logic                q_push, q_pop, q_flush;
  logic                q_full, q_almost_full, q_empty;
  logic [ENTRY_W-1:0]  q_head;

  fetch_queue #(
    .WIDTH(ENTRY_W),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock       (clock),
    .reset       (reset),
    .flush       (q_flush),
    .push        (q_push),
    .push_data   ({hi_q, mem_data, fetch_pc_q}),
    .pop         (q_pop),
    .head_data   (q_head),
    .full        (q_full),
    .almost_full (q_almost_full),
    .empty       (q_empty)
  );

  assign instr_valid = !q_empty && !redirect;
  assign instr       = q_head[ENTRY_W-1:WORD_W];
  assign instr_pc    = q_head[WORD_W-1:0];
  assign q_pop       = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hi_d       = hi_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = fetch_pc_q;
    unique case (state_q)
      FETCH_HI: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          hi_d    = mem_data;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc_q + 16'd1;
        if (mem_ack) begin
          q_push     = 1'b1;
          fetch_pc_d = fetch_pc_q + 16'd2;
          // Park when this push fills the last slot and decode is not draining.
          state_d    = (q_almost_full && !q_pop) ? HOLD : FETCH_HI;
        end
      end
      HOLD: begin
        if (q_pop || !q_full) begin
          state_d = FETCH_HI;
        end
      end
      default: state_d = FETCH_HI;
    endcase
    // Redirect discards the in-flight word and restarts fetch next cycle.
    if (redirect) begin
      q_push     = 1'b0;
      q_flush    = 1'b1;
      fetch_pc_d = redirect_pc;
      state_d    = FETCH_HI;
      mem_req    = 1'b0;
    end
    if (reset) begin
      mem_req = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH_HI;
      fetch_pc_q <= RESET_PC;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hi_q       <= hi_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a configurable-latency memory returning addr^16'hA5A5.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [15:0] instr_pc;

  int unsigned lat  = 0;
  int unsigned wcnt = 0;
  int          tests  = 0;
  int          failed = 0;

  instruction_fetch #(
    .RESET_PC(16'h0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clock = ~clock;

  assign mem_data = mem_addr ^ 16'hA5A5;
  assign mem_ack  = mem_req && (wcnt == lat);

  always @(posedge clock) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Zero-wait streaming with decoder always ready.
    lat = 0;
    instr_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    check("rst_req",   mem_req,     32'd0);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_instr", instr,       32'd0);
    check("rst_pc",    instr_pc,    32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("s_req",  mem_req,  32'd1);
      check("s_addr", mem_addr, 32'(i));
      if (i == 2) begin
        check("s_valid2", instr_valid, 32'd1);
        check("s_instr2", instr,       32'hA5A5A5A4);
        check("s_pc2",    instr_pc,    32'h0);
      end
      if (i == 3) check("s_valid3", instr_valid, 32'd0);
      if (i == 4) begin
        check("s_instr4", instr,    32'hA5A7A5A6);
        check("s_pc4",    instr_pc, 32'h2);
      end
      tick();
    end

    // Decoder stalled from reset: queue fills, fetch parks, resumes after a pop.
    instr_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    check("h_req",   mem_req,     32'd0);
    check("h_valid", instr_valid, 32'd1);
    check("h_pc",    instr_pc,    32'h0);
    check("h_instr", instr,       32'hA5A5A5A4);
    repeat (2) tick();
    check("h_req_stable", mem_req,  32'd0);
    check("h_pc_stable",  instr_pc, 32'h0);
    instr_ready = 1'b1;
    #1;
    check("h_valid_pop", instr_valid, 32'd1);
    tick();
    check("h_resume_req",  mem_req,  32'd1);
    check("h_resume_addr", mem_addr, 32'h4);
    check("h_next_pc",     instr_pc, 32'h2);
    tick();
    check("h_lo_addr", mem_addr, 32'h5);

    // Redirect in FETCH_LO with ack and a non-empty queue.
    instr_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    check("r_pre_addr",  mem_addr,    32'h3);
    check("r_pre_valid", instr_valid, 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h1234;
    #1;
    check("r_valid_now", instr_valid, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("r_valid_next", instr_valid, 32'd0);
    check("r_req",        mem_req,     32'd1);
    check("r_addr",       mem_addr,    32'h1234);
    instr_ready = 1'b1;
    tick();
    check("r_lo_addr", mem_addr,    32'h1235);
    check("r_empty",   instr_valid, 32'd0);
    tick();
    check("r_valid", instr_valid, 32'd1);
    check("r_instr", instr,       32'hB791B790);
    check("r_pc",    instr_pc,    32'h1234);
    check("r_addr2", mem_addr,    32'h1236);

    // Redirect to the top of the address space wraps to zero.
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    #1;
    check("w_req_redirect", mem_req, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("w_addr_hi", mem_addr,    32'hFFFF);
    check("w_req",     mem_req,     32'd1);
    check("w_valid0",  instr_valid, 32'd0);
    tick();
    check("w_addr_lo", mem_addr, 32'h0000);
    tick();
    check("w_valid", instr_valid, 32'd1);
    check("w_pc",    instr_pc,    32'hFFFF);
    check("w_instr", instr,       32'h5A5AA5A5);
    check("w_next",  mem_addr,    32'h0001);

    // Three wait cycles per word: address holds, one instruction per 8 cycles.
    lat = 3;
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      check("l_req",   mem_req,     32'd1);
      check("l_addr",  mem_addr,    32'(i / 4));
      check("l_valid", instr_valid, ((i == 8) || (i == 16)) ? 32'd1 : 32'd0);
      if (i == 8)  check("l_pc8",  instr_pc, 32'h0);
      if (i == 16) check("l_pc16", instr_pc, 32'h2);
      tick();
    end

    // Reset during a pending slow request.
    reset = 1'b1;
    #1;
    check("x_req_now", mem_req, 32'd0);
    tick();
    check("x_req",   mem_req,     32'd0);
    check("x_valid", instr_valid, 32'd0);
    reset = 1'b0;
    #1;
    check("x_restart_req",  mem_req,  32'd1);
    check("x_restart_addr", mem_addr, 32'h0);
    repeat (3) tick();
    check("x_hold_addr", mem_addr, 32'h0);
    tick();
    check("x_lo_addr", mem_addr, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
